// File: rtl/alu_div_sequencer.sv
// Restoring unsigned divider that sequences the shared ALU, one quotient bit per cycle.
// Divide by zero returns all-ones quotient and the dividend as remainder.
module alu_div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry
);

    // Handshake: start is accepted only while busy=0 (IDLE); operands are
    // captured on that edge. done pulses for one cycle with results valid;
    // starts seen while busy=1 are dropped, not queued.

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] s;
    logic             take;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        alu_a      = '0;
        alu_b      = '0;
        alu_ctrl   = 3'b000;
        s          = {r[WIDTH-2:0], q[WIDTH-1]};
        take       = 1'b0;
        r_next     = r;
        q_next     = q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                alu_a    = s;
                alu_b    = d;
                alu_ctrl = 3'b001;
                // A bit shifted out of R means the true partial remainder exceeds D.
                take     = alu_carry | r[WIDTH-1];
                r_next   = take ? alu_result : s;
                q_next   = {q[WIDTH-2:0], take};
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        r   <= '0;
                        q   <= dividend;
                        d   <= divisor;
                        cnt <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
